// File: rtl/datafeed_gen.sv
// Programmable test-pattern source: a clock-enable rate divider, four pattern generators,
// and a single-slot valid/ready output with sticky overrun and an accepted-sample counter.
module datafeed_gen #(
   parameter int                DATA_W = 16,
   parameter int                DIV_W  = 30,
   parameter logic [DATA_W-1:0] POLY   = 16'hB400,
   parameter int                CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [DIV_W-1:0]  div_n,
   input  logic [DATA_W-1:0] limit,
   input  logic [DATA_W-1:0] seed,
   input  logic              load,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic [CNT_W-1:0]  sample_count
);

   typedef enum logic [1:0] {
      MODE_COUNT = 2'd0,
      MODE_RAMP  = 2'd1,
      MODE_LFSR  = 2'd2,
      MODE_CONST = 2'd3
   } mode_e;

   logic [DIV_W-1:0]  divCnt_q, divCnt_d;
   logic [DATA_W-1:0] gen_q, gen_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              tick;
   logic              slotFree;
   logic              accept;
   mode_e             curMode;
   logic [DATA_W-1:0] emitValue;
   logic [DATA_W-1:0] nextValue;

   assign curMode = mode_e'(mode);

   // CONST emits the live seed so a seed change shows up at the very next tick.
   always_comb begin
      emitValue = gen_q;
      nextValue = gen_q;
      case (curMode)
         MODE_COUNT: nextValue = gen_q + DATA_W'(1);
         MODE_RAMP:  nextValue = (gen_q >= limit) ? '0 : gen_q + DATA_W'(1);
         MODE_LFSR:  nextValue = (gen_q == '0) ? DATA_W'(1)
                                 : ((gen_q >> 1) ^ (gen_q[0] ? POLY : '0));
         MODE_CONST: begin
            emitValue = seed;
            nextValue = seed;
         end
         default:    nextValue = gen_q;
      endcase
   end

   always_comb begin
      tick      = en && (divCnt_q >= div_n);
      slotFree  = !valid_q || out_ready;
      accept    = valid_q && out_ready;

      divCnt_d  = divCnt_q;
      gen_d     = gen_q;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      count_d   = count_q;

      if (tick) begin
         divCnt_d = '0;
      end else if (en) begin
         divCnt_d = divCnt_q + DIV_W'(1);
      end

      if (accept) begin
         count_d = count_q + CNT_W'(1);
         valid_d = 1'b0;
      end

      // A tick into an occupied slot drops the sample rather than queueing it.
      if (tick) begin
         if (slotFree) begin
            data_d  = emitValue;
            valid_d = 1'b1;
            gen_d   = nextValue;
         end else begin
            overrun_d = 1'b1;
         end
      end

      if (load) begin
         gen_d     = seed;
         divCnt_d  = '0;
         valid_d   = 1'b0;
         overrun_d = 1'b0;
         data_d    = data_q;
         count_d   = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         divCnt_q  <= '0;
         gen_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         count_q   <= '0;
      end else begin
         divCnt_q  <= divCnt_d;
         gen_q     <= gen_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         count_q   <= count_d;
      end
   end

   assign out_data     = data_q;
   assign out_valid    = valid_q;
   assign overrun      = overrun_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_datafeed_gen.sv
// Directed bench for datafeed_gen: expected samples are queued by the stimulus process
// and a negedge monitor pops and compares one per accepted handshake.
module tb_datafeed_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic [1:0]  mode;
   logic [29:0] div_n;
   logic [15:0] limit;
   logic [15:0] seed;
   logic        load;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
   logic [31:0] sample_count;

   int          totalChecks = 0;
   int          badChecks   = 0;
   logic [15:0] expQ[$];

   datafeed_gen #(
      .DATA_W(16),
      .DIV_W (30),
      .POLY  (16'hB400),
      .CNT_W (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .mode        (mode),
      .div_n       (div_n),
      .limit       (limit),
      .seed        (seed),
      .load        (load),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overrun     (overrun),
      .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic enV, input logic readyV,
                                input logic [1:0] modeV, input logic [29:0] divV);
      en        = enV;
      out_ready = readyV;
      mode      = modeV;
      div_n     = divV;
   endtask

   task automatic loadSeed(input logic [15:0] v);
      seed = v;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   // Waits until every queued sample has been accepted, then parks the generator.
   task automatic drainQueue(input int maxCycles, output int cycles);
      cycles = -1;
      for (int i = 1; i <= maxCycles; i++) begin
         @(posedge clk); #1;
         if (expQ.size() == 0) begin
            cycles = i;
            break;
         end
      end
      en        = 1'b0;
      out_ready = 1'b0;
      expQ.delete();
   endtask

   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL unexpected sample: got %h with empty queue", out_data);
         end else begin
            checkOutput("sample", {16'h0, out_data}, {16'h0, expQ.pop_front()});
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc;
      int validSeen;

      clk = 1'b0; rst = 1'b1; en = 1'b0; mode = 2'd0; div_n = '0;
      limit = '0; seed = '0; load = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("reset out_valid", {31'h0, out_valid}, 32'd0);
      checkOutput("reset out_data", {16'h0, out_data}, 32'd0);
      checkOutput("reset overrun", {31'h0, overrun}, 32'd0);
      checkOutput("reset count", sample_count, 32'd0);

      $display("[TB] count mode, div_n=3");
      for (int i = 0; i < 4; i++) expQ.push_back(16'(i));
      applyStimulus(1'b1, 1'b1, 2'd0, 30'd3);
      drainQueue(40, cyc);
      checkOutput("count cycles", cyc, 32'd17);
      checkOutput("count accepted", sample_count, 32'd4);
      checkOutput("count overrun", {31'h0, overrun}, 32'd0);

      $display("[TB] ramp mode, limit=3");
      loadSeed(16'h0000);
      limit = 16'd3;
      for (int i = 0; i < 8; i++) expQ.push_back(16'(i % 4));
      applyStimulus(1'b1, 1'b1, 2'd1, 30'd0);
      drainQueue(40, cyc);
      checkOutput("ramp cycles", cyc, 32'd9);
      checkOutput("ramp accepted", sample_count, 32'd12);

      $display("[TB] lfsr mode");
      loadSeed(16'h0001);
      expQ.push_back(16'h0001); expQ.push_back(16'hB400); expQ.push_back(16'h5A00);
      expQ.push_back(16'h2D00); expQ.push_back(16'h1680);
      applyStimulus(1'b1, 1'b1, 2'd2, 30'd0);
      drainQueue(40, cyc);
      checkOutput("lfsr cycles", cyc, 32'd6);
      checkOutput("lfsr accepted", sample_count, 32'd17);
      loadSeed(16'h0000);
      expQ.push_back(16'h0000); expQ.push_back(16'h0001); expQ.push_back(16'hB400);
      applyStimulus(1'b1, 1'b1, 2'd2, 30'd0);
      drainQueue(40, cyc);
      checkOutput("lfsr zero cycles", cyc, 32'd4);
      checkOutput("lfsr zero accepted", sample_count, 32'd20);

      $display("[TB] backpressure and overrun");
      loadSeed(16'h0010);
      expQ.push_back(16'h0010); expQ.push_back(16'h0011);
      applyStimulus(1'b1, 1'b0, 2'd0, 30'd1);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 2) begin
            checkOutput("bp first valid", {31'h0, out_valid}, 32'd1);
            checkOutput("bp first overrun", {31'h0, overrun}, 32'd0);
         end
         if (k == 4) checkOutput("bp second tick overrun", {31'h0, overrun}, 32'd1);
      end
      checkOutput("bp held data", {16'h0, out_data}, 32'h0010);
      checkOutput("bp count held", sample_count, 32'd20);
      out_ready = 1'b1;
      drainQueue(20, cyc);
      checkOutput("bp drain cycles", cyc, 32'd3);
      checkOutput("bp accepted", sample_count, 32'd22);
      checkOutput("bp overrun sticky", {31'h0, overrun}, 32'd1);

      $display("[TB] load coinciding with tick");
      expQ.push_back(16'h00F0); expQ.push_back(16'h00F1); expQ.push_back(16'h00F2);
      seed = 16'h00F0;
      load = 1'b1;
      applyStimulus(1'b1, 1'b1, 2'd0, 30'd0);
      @(posedge clk); #1;
      load = 1'b0;
      checkOutput("load valid cleared", {31'h0, out_valid}, 32'd0);
      checkOutput("load overrun cleared", {31'h0, overrun}, 32'd0);
      checkOutput("load data held", {16'h0, out_data}, 32'h0011);
      drainQueue(20, cyc);
      checkOutput("load drain cycles", cyc, 32'd4);
      checkOutput("load accepted", sample_count, 32'd25);

      $display("[TB] reset with load");
      rst = 1'b1; load = 1'b1; seed = 16'h00F0;
      @(posedge clk); #1;
      rst = 1'b0; load = 1'b0;
      checkOutput("rst+load data", {16'h0, out_data}, 32'd0);
      checkOutput("rst+load valid", {31'h0, out_valid}, 32'd0);
      checkOutput("rst+load count", sample_count, 32'd0);
      expQ.push_back(16'h0000); expQ.push_back(16'h0001);
      applyStimulus(1'b1, 1'b1, 2'd0, 30'd0);
      drainQueue(20, cyc);
      checkOutput("rst+load drain cycles", cyc, 32'd3);
      checkOutput("rst+load accepted", sample_count, 32'd2);

      $display("[TB] const mode");
      loadSeed(16'hA5A5);
      for (int i = 0; i < 3; i++) expQ.push_back(16'hA5A5);
      applyStimulus(1'b1, 1'b1, 2'd3, 30'd2);
      drainQueue(40, cyc);
      checkOutput("const cycles", cyc, 32'd10);
      expQ.push_back(16'h1234); expQ.push_back(16'h1234);
      seed = 16'h1234;
      applyStimulus(1'b1, 1'b1, 2'd3, 30'd2);
      drainQueue(40, cyc);
      checkOutput("const new seed cycles", cyc, 32'd6);
      checkOutput("const accepted", sample_count, 32'd7);

      applyStimulus(1'b0, 1'b1, 2'd3, 30'd2);
      validSeen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (out_valid) validSeen++;
      end
      checkOutput("disabled valid pulses", validSeen, 32'd0);
      expQ.push_back(16'h1234);
      applyStimulus(1'b1, 1'b1, 2'd3, 30'd2);
      drainQueue(20, cyc);
      checkOutput("frozen divider cycles", cyc, 32'd3);
      checkOutput("final accepted", sample_count, 32'd8);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/datafeed_gen.md
Name: datafeed_gen

Overview:
Parametrised test-pattern source feeding the SDRAM/Nios data path. It is the successor to the fixed single-pattern feed.
- Generates samples at a programmable rate from an internal clock-enable divider. The divider output is never used as a clock.
- Four pattern modes: count, ramp-to-limit, LFSR, constant.
- Output uses a valid/ready handshake with overrun detection and an accepted-sample counter.

Parameters:
DATA_W, 16, sample width in bits.
DIV_W, 30, width of the rate divider counter and div_n.
POLY, 16'hB400, Galois LFSR feedback mask (DATA_W bits).
CNT_W, 32, width of the accepted-sample counter.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
en  in  1  run enable; when 0 the divider holds and no ticks occur.
mode  in  2  0=COUNT, 1=RAMP, 2=LFSR, 3=CONST.
div_n  in  DIV_W  tick period minus 1, in clk cycles.
limit  in  DATA_W  RAMP upper bound (inclusive).
seed  in  DATA_W  start value for load; constant value in CONST.
load  in  1  single-cycle restart of the generator.
out_data  out  DATA_W  sample.
out_valid  out  1  sample available.
out_ready  in  1  downstream accepts.
overrun  out  1  sticky: a tick found the output slot occupied.
sample_count  out  CNT_W  number of accepted handshakes.

Behaviour:
- Reset (rst=1 at posedge):
  - div_cnt=0, gen value=0, out_data=0, out_valid=0, overrun=0, sample_count=0.
  - rst has priority over load and all other inputs.
- Divider:
  - tick = en && (div_cnt >= div_n).
  - On tick, div_cnt<=0; else if en, div_cnt<=div_cnt+1; else div_cnt holds.
  - div_n=0 gives a tick every enabled cycle.
  - Lowering div_n below div_cnt mid-count ticks on the next enabled cycle (>= compare).
- Slot free: free = !out_valid || out_ready.
- Accept: out_valid && out_ready → sample_count+1, wrapping at 2^CNT_W.
- Tick with free=1:
  - out_data<=gen value and out_valid<=1.
  - Gen value advances in the same edge.
  - Sample appears with out_valid=1 in the cycle after the tick cycle.
  - Accept and tick in the same cycle: the new sample replaces the old one, out_valid stays 1, and count increments once.
- Tick with free=0:
  - overrun<=1 (sticky).
  - out_data and the gen value do not change; the sample is skipped, not queued.
- Handshake: while out_valid && !out_ready, out_data is stable. out_valid deasserts only on accept without a concurrent tick.
- Advance rules (mode sampled at tick; a mode change takes effect at the next tick):
  - COUNT: v+1, wrapping from 2^DATA_W-1 to 0.
  - RAMP: if v >= limit then 0, else v+1.
    - limit=0 gives a constant 0 stream.
    - A v above a newly lowered limit returns to 0 on the next advance.
  - LFSR: if v==0, next=1 (lock-up escape). Else next=(v>>1) ^ (v[0] ? POLY : 0).
  - CONST: the emitted sample is seed, taken at tick time. v<=seed.
- Load (rst=0):
  - v<=seed, div_cnt<=0, out_valid<=0, overrun<=0.
  - out_data and sample_count hold.
  - Load overrides a tick in the same cycle.
  - The first tick after load emits seed.
- en=0: no new samples. A pending out_valid can still be accepted.

Test Plan:
1. rst 1 cycle, then en=1, mode=0, div_n=3, out_ready=1 → out_valid pulses every 4 cycles; out_data 0,1,2,3,…; overrun=0; sample_count=4 after 4 pulses.
2. mode=1, limit=3, div_n=0, ready=1 → out_data sequence 0,1,2,3,0,1,… with out_valid held high continuously.
3. mode=2, load with seed=16'h0001, div_n=0, ready=1 → samples 0001, B400, 5A00, 2D00, …; in a separate run, load seed=0 → samples 0000, 0001, B400.
4. mode=0, div_n=1, out_ready=0 for 6 cycles → out_data held at first sample, overrun=1 from the second tick onward, sample_count=0; on ready=1 the held sample is accepted and the next sample equals held+1.
5. Mid-stream, load=1 with seed=16'h00F0 coinciding with a tick → out_valid=0 next cycle, overrun cleared, the next tick emits 00F0; a rst asserted with load yields value 0.
6. mode=3, seed=16'hA5A5, div_n=2 → every sample is A5A5; seed changed to 1234 mid-run → the next sample is 1234; en=0 → no further out_valid pulses and div_cnt frozen.
